// File: rtl/uart_rx_pkg.sv
// Shared types and default constants for the UART receive sequencer.
// DEF_PARITY_ODD exists only when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  localparam int DEF_OVERSAMPLE  = 16;
  localparam int DEF_DATA_BITS   = 8;
  localparam int DEF_SYNC_STAGES = 2;
`ifdef UART_RX_PARITY_EN
  localparam int DEF_PARITY_ODD  = 0;
`endif

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Oversample counter for the receive sequencer: flags the start-bit midpoint and the end of
// each full bit period. Advances only on sample ticks; cleared by the FSM.
module uart_rx_bit_timer
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_clear,
  output logic o_mid_pt,
  output logic o_bit_end
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] r_cnt;

  // Explicit wrap at OVERSAMPLE-1 so non-power-of-two ratios still work.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      if (i_clear || o_bit_end) r_cnt <= '0;
      else                      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_mid_pt  = (r_cnt == MID_CNT);
  assign o_bit_end = (r_cnt == LAST_CNT);

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: line synchroniser, frame FSM, shift register and valid/ack handshake.
// Define UART_RX_PARITY_EN to add the parity bit phase and the PARITY_ODD parameter.
module uart_rx_sequencer
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
`ifdef UART_RX_PARITY_EN
  , parameter int PARITY_ODD = DEF_PARITY_ODD
`endif
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_sample_tick,
  input  logic                 i_rx_in,
  input  logic                 i_data_ack,
  output logic [DATA_BITS-1:0] o_data_out,
  output logic                 o_data_valid,
  output logic                 o_busy,
  output logic                 o_frame_err,
  output logic                 o_overrun_err,
  output logic                 o_parity_err
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  state_t               r_state, w_stateNext;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                 w_rxS;
  logic [IDX_W-1:0]     r_bitIdx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_done, r_stopBit;
  logic                 w_midPt, w_bitEnd;
  logic                 w_timerClr, w_idxClr, w_shiftEn, w_stopSample;
  logic                 w_parityErr;
  logic [DATA_BITS-1:0] r_dataOut;
  logic                 r_dataValid, r_frameErr, r_overrunErr, r_parityErr;
`ifdef UART_RX_PARITY_EN
  logic                 w_parCap, r_parityBit;
`endif

  // Synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync[0] <= i_rx_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_rxS = r_sync[SYNC_STAGES-1];

  uart_rx_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_tick    (i_sample_tick),
    .i_clear   (w_timerClr),
    .o_mid_pt  (w_midPt),
    .o_bit_end (w_bitEnd)
  );

  always_comb begin
    w_stateNext  = r_state;
    w_timerClr   = 1'b0;
    w_idxClr     = 1'b0;
    w_shiftEn    = 1'b0;
    w_stopSample = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_parCap     = 1'b0;
`endif
    if (i_sample_tick) begin
      unique case (r_state)
        IDLE: begin
          w_timerClr = 1'b1;
          if (!w_rxS) w_stateNext = START;
        end
        START: if (w_midPt) begin
          w_timerClr  = 1'b1;
          w_idxClr    = 1'b1;
          w_stateNext = w_rxS ? IDLE : DATA;
        end
        DATA: if (w_bitEnd) begin
          w_shiftEn = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (r_bitIdx == LAST_IDX) w_stateNext = PARITY;
`else
          if (r_bitIdx == LAST_IDX) w_stateNext = STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (w_bitEnd) begin
          w_parCap    = 1'b1;
          w_stateNext = STOP;
        end
`endif
        STOP: if (w_bitEnd) begin
          w_stopSample = 1'b1;
          w_stateNext  = w_rxS ? IDLE : WAIT_IDLE;
        end
        WAIT_IDLE: begin
          w_timerClr = 1'b1;
          if (w_rxS) w_stateNext = IDLE;
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

  // r_done delays completion by one clock so the handshake sees a settled stop bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_bitIdx  <= '0;
      r_shift   <= '0;
      r_done    <= 1'b0;
      r_stopBit <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_done  <= w_stopSample;
      if (w_idxClr)       r_bitIdx <= '0;
      else if (w_shiftEn) r_bitIdx <= r_bitIdx + IDX_W'(1);
      if (w_shiftEn)    r_shift   <= {w_rxS, r_shift[DATA_BITS-1:1]};
      if (w_stopSample) r_stopBit <= w_rxS;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_parityBit <= 1'b0;
    else if (w_parCap) r_parityBit <= w_rxS;
  end

  assign w_parityErr = ((^r_shift) ^ r_parityBit) != 1'(PARITY_ODD);
`else
  assign w_parityErr = 1'b0;
`endif

  // A frame landing on an unacknowledged character is dropped and flagged as overrun.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dataOut    <= '0;
      r_dataValid  <= 1'b0;
      r_frameErr   <= 1'b0;
      r_overrunErr <= 1'b0;
      r_parityErr  <= 1'b0;
    end else if (r_done) begin
      if (!r_dataValid || i_data_ack) begin
        r_dataOut   <= r_shift;
        r_frameErr  <= ~r_stopBit;
        r_parityErr <= w_parityErr;
        r_dataValid <= 1'b1;
      end else begin
        r_overrunErr <= 1'b1;
      end
    end else if (i_data_ack && r_dataValid) begin
      r_dataValid  <= 1'b0;
      r_overrunErr <= 1'b0;
    end
  end

  assign o_data_out    = r_dataOut;
  assign o_data_valid  = r_dataValid;
  assign o_busy        = (r_state != IDLE);
  assign o_frame_err   = r_frameErr;
  assign o_overrun_err = r_overrunErr;
  assign o_parity_err  = r_parityErr;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer: good frames, start glitches, framing errors, overrun,
// mid-frame reset and (with UART_RX_PARITY_EN) parity, at two sample_tick rates.
module tb_uart_rx_sequencer;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] dout;
  logic       valid, busy, ferr, oerr, perr;

  int tickDiv = 1;
  int tickCnt = 0;
  int checks  = 0;
  int passed  = 0;

  uart_rx_sequencer #(
    .OVERSAMPLE (OS),
    .DATA_BITS  (8),
    .SYNC_STAGES(2)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_sample_tick(tick),
    .i_rx_in      (rx),
    .i_data_ack   (ack),
    .o_data_out   (dout),
    .o_data_valid (valid),
    .o_busy       (busy),
    .o_frame_err  (ferr),
    .o_overrun_err(oerr),
    .o_parity_err (perr)
  );

  always #5 clk = ~clk;

  // sample_tick is one clock wide, every tickDiv-th rising edge.
  always @(negedge clk) begin
    tickCnt = (tickCnt + 1 >= tickDiv) ? 0 : tickCnt + 1;
    tick    = (tickCnt == 0);
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Returns 1 time unit after the n-th sample tick edge.
  task automatic waitTicks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (tick !== 1'b1);
    end
    #1;
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic stopBit,
                           input bit withPar, input logic parBit);
    rx = 1'b0;
    waitTicks(OS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      waitTicks(OS);
    end
    if (withPar) begin
      rx = parBit;
      waitTicks(OS);
    end
    rx = stopBit;
    waitTicks(OS);
  endtask

  task automatic doAck();
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    ack   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({valid, busy, ferr, oerr, perr} !== 5'b0)
      $display("[TB] FAIL reset_flags: got %b expected 00000", {valid, busy, ferr, oerr, perr});
    else passed++;
    checks++; if (dout !== 8'h00) $display("[TB] FAIL reset_data: got %h expected 00", dout);
    else passed++;
    rst_n = 1'b1;
    waitTicks(4);
  endtask

  task automatic test_frame_ok();
    int lat, expLat;
    bit got;
    lat = 0;
    got = 0;
    // Start seen 3 edges in at full rate (2 sync flops), else on the first tick; then
    // 152 ticks to the stop sample; the completion edge is itself a tick only at full rate.
    expLat = (tickDiv == 1) ? 156 : 153;
    fork
      sendFrame(8'h55, 1'b1, 1'b0, 1'b0);
      begin
        for (int i = 0; i < 2000 && !got; i++) begin
          @(posedge clk);
          if (tick) lat++;
          #1;
          if (valid) got = 1;
        end
      end
    join
    checks++; if (!got) $display("[TB] FAIL ok_valid_rise: got no valid expected valid=1");
    else passed++;
    checks++; if (lat != expLat) $display("[TB] FAIL ok_latency: got %0d expected %0d", lat, expLat);
    else passed++;
    checks++; if (dout !== 8'h55) $display("[TB] FAIL ok_data: got %h expected 55", dout);
    else passed++;
    checks++; if (ferr !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL ok_ferr_busy: got %b%b expected 00", ferr, busy);
    else passed++;
    doAck();
    checks++; if (valid !== 1'b0) $display("[TB] FAIL ok_ack: got %b expected 0", valid);
    else passed++;
    waitTicks(2);
  endtask

  task automatic test_glitch();
    int detTick;
    detTick = (tickDiv == 1) ? 3 : 1;
    rx = 1'b0;
    waitTicks(4);
    rx = 1'b1;
    waitTicks(detTick + 7 - 4);
    checks++; if (busy !== 1'b1) $display("[TB] FAIL glitch_busy_before: got %b expected 1", busy);
    else passed++;
    waitTicks(1);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL glitch_abort: got %b expected 0", busy);
    else passed++;
    waitTicks(20);
    checks++; if (valid !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL glitch_idle: got valid=%b busy=%b expected 0 0", valid, busy);
    else passed++;
  endtask

  task automatic test_frame_err();
    sendFrame(8'hA3, 1'b0, 1'b0, 1'b0);
    waitTicks(40);
    checks++; if (dout !== 8'hA3 || valid !== 1'b1)
      $display("[TB] FAIL ferr_data: got %h v=%b expected a3 v=1", dout, valid);
    else passed++;
    checks++; if (ferr !== 1'b1) $display("[TB] FAIL ferr_flag: got %b expected 1", ferr);
    else passed++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL ferr_busy_low: got %b expected 1", busy);
    else passed++;
`ifndef UART_RX_PARITY_EN
    checks++; if (perr !== 1'b0) $display("[TB] FAIL ferr_perr_tied: got %b expected 0", perr);
    else passed++;
`endif
    rx = 1'b1;
    waitTicks(3);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL ferr_busy_high: got %b expected 0", busy);
    else passed++;
    doAck();
    waitTicks(2);
  endtask

  task automatic test_overrun();
    sendFrame(8'h11, 1'b1, 1'b0, 1'b0);
    sendFrame(8'h22, 1'b1, 1'b0, 1'b0);
    waitTicks(2);
    checks++; if (dout !== 8'h11) $display("[TB] FAIL ovr_data: got %h expected 11", dout);
    else passed++;
    checks++; if (oerr !== 1'b1 || valid !== 1'b1)
      $display("[TB] FAIL ovr_flag: got oerr=%b v=%b expected 1 1", oerr, valid);
    else passed++;
    doAck();
    checks++; if (valid !== 1'b0 || oerr !== 1'b0)
      $display("[TB] FAIL ovr_ack: got v=%b oerr=%b expected 0 0", valid, oerr);
    else passed++;
    waitTicks(2);
  endtask

  task automatic test_reset_midframe();
    sendFrame(8'h5A, 1'b1, 1'b0, 1'b0);
    waitTicks(2);
    checks++; if (valid !== 1'b1 || dout !== 8'h5A)
      $display("[TB] FAIL rstmid_pre: got v=%b d=%h expected 1 5a", valid, dout);
    else passed++;
    rx = 1'b0;
    waitTicks(OS);
    rx = 1'b1;
    waitTicks(OS * 3 + 8);
    rst_n = 1'b0;
    #1;
    checks++; if ({valid, busy, ferr, oerr, perr} !== 5'b0 || dout !== 8'h00)
      $display("[TB] FAIL rstmid_clear: got flags=%b d=%h expected 00000 00",
               {valid, busy, ferr, oerr, perr}, dout);
    else passed++;
    waitTicks(2);
    rst_n = 1'b1;
    waitTicks(4);
    sendFrame(8'h3C, 1'b1, 1'b0, 1'b0);
    waitTicks(2);
    checks++; if (dout !== 8'h3C || valid !== 1'b1)
      $display("[TB] FAIL rstmid_next: got d=%h v=%b expected 3c 1", dout, valid);
    else passed++;
    doAck();
    waitTicks(2);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    sendFrame(8'h07, 1'b1, 1'b1, 1'b0);
    waitTicks(2);
    checks++; if (dout !== 8'h07 || perr !== 1'b1)
      $display("[TB] FAIL par_bad: got d=%h perr=%b expected 07 1", dout, perr);
    else passed++;
    doAck();
    waitTicks(2);
    sendFrame(8'h07, 1'b1, 1'b1, 1'b1);
    waitTicks(2);
    checks++; if (dout !== 8'h07 || perr !== 1'b0)
      $display("[TB] FAIL par_good: got d=%h perr=%b expected 07 0", dout, perr);
    else passed++;
    doAck();
    waitTicks(2);
  endtask
`endif

  initial begin
    $display("[TB] starting uart_rx_sequencer bench");
    test_reset();
    test_frame_ok();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    tickDiv = 3;
    waitTicks(3);
    test_frame_ok();
    test_glitch();
    test_frame_err();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
